// File: rtl/mnist_pool_binarizer.sv
// Pools a row-major IMG_W x IMG_W pixel stream into POOLxPOOL tile sums and thresholds each to one bit.
// Optional MNIST_POOL_LAST_CHECK_EN: checks pix_last framing and resynchronises on an early pix_last.
module mnist_pool_binarizer #(
    parameter int IMG_W  = 28,
    parameter int POOL   = 4,
    parameter int PIX_W  = 8,
    parameter int THRESH = 128,
    localparam int GRID  = IMG_W / POOL,
    localparam int OUT_W = GRID * GRID
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_last,
    output logic [OUT_W-1:0] vec_bits,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             frame_err
);
    localparam int CW    = $clog2(IMG_W);
    localparam int TW    = (GRID > 1) ? $clog2(GRID) : 1;
    localparam int BW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ACC_W = $clog2(POOL * POOL * ((1 << PIX_W) - 1) + 1);
    localparam int TSUM  = POOL * POOL * THRESH;

    logic [CW-1:0]    col_q, col_d, row_q, row_d;
    logic [ACC_W-1:0] acc_q [GRID];
    logic [ACC_W-1:0] acc_d [GRID];
    logic [OUT_W-1:0] build_q, build_d, vec_bits_q, vec_bits_d;
    logic             done_q, done_d, vec_valid_q, vec_valid_d;

    logic             pix_fire, last_pix, tile_close, tile_bit, early_last;
    logic [TW-1:0]    tile_idx;
    logic [BW-1:0]    bit_idx;
    logic [ACC_W-1:0] sum;

    assign last_pix   = (row_q == CW'(IMG_W - 1)) && (col_q == CW'(IMG_W - 1));
    assign pix_ready  = !(last_pix && vec_valid_q && !vec_ready);
    assign pix_fire   = pix_valid && pix_ready;
    assign tile_idx   = TW'(32'(col_q) / POOL);
    assign tile_close = (32'(row_q) % POOL == POOL - 1) && (32'(col_q) % POOL == POOL - 1);
    assign bit_idx    = BW'((32'(row_q) / POOL) * GRID + 32'(col_q) / POOL);
    assign sum        = acc_q[tile_idx] + ACC_W'(pix_data);
    assign tile_bit   = 32'(sum) >= TSUM;

`ifdef MNIST_POOL_LAST_CHECK_EN
    logic err_q;
    assign early_last = pix_fire && pix_last && !last_pix;
    assign frame_err  = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (pix_fire && (pix_last != last_pix))
            err_q <= 1'b1;
    end
`else
    logic unused_pix_last;
    assign unused_pix_last = pix_last;
    assign early_last      = 1'b0;
    assign frame_err       = 1'b0;
`endif

    // The completed frame sits in build_q for one cycle (done_q) before moving to the output register.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        acc_d       = acc_q;
        build_d     = done_q ? '0 : build_q;
        done_d      = 1'b0;
        vec_bits_d  = vec_bits_q;
        vec_valid_d = vec_valid_q;
        if (vec_valid_q && vec_ready)
            vec_valid_d = 1'b0;
        if (done_q) begin
            vec_bits_d  = build_q;
            vec_valid_d = 1'b1;
        end
        if (pix_fire) begin
            acc_d[tile_idx] = tile_close ? '0 : sum;
            if (tile_close)
                build_d[bit_idx] = tile_bit;
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = last_pix ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            done_d = last_pix;
            if (early_last) begin
                col_d   = '0;
                row_d   = '0;
                build_d = '0;
                done_d  = 1'b0;
                for (int i = 0; i < GRID; i++)
                    acc_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            build_q     <= '0;
            done_q      <= 1'b0;
            vec_bits_q  <= '0;
            vec_valid_q <= 1'b0;
            for (int i = 0; i < GRID; i++)
                acc_q[i] <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            build_q     <= build_d;
            done_q      <= done_d;
            vec_bits_q  <= vec_bits_d;
            vec_valid_q <= vec_valid_d;
            for (int i = 0; i < GRID; i++)
                acc_q[i] <= acc_d[i];
        end
    end

    assign vec_bits  = vec_bits_q;
    assign vec_valid = vec_valid_q;
endmodule
